// File: rtl/fdd_pkg.sv
// Shared constants and helpers for the floppy bus multiplexer: slot limit,
// default drive ID word, cylinder counter sizing and edge detectors.
package fdd_pkg;

    localparam int          NDRV_MAX     = 4;
    localparam logic [31:0] DRIVE_ID_DEF = 32'hFFFF_FFFF;
    localparam logic [4:0]  IDX_TOP      = 5'd31;

    function automatic int cylw(input int maxcyl);
        return $clog2(maxcyl + 1);
    endfunction

    function automatic logic rise(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

    function automatic logic fall(input logic cur, input logic prev);
        return ~cur & prev;
    endfunction

endpackage

// File: rtl/fdd_bus_mux_if.sv
// Amiga floppy connector signals: host-driven controls and drive returns.
interface fdd_bus_mux_if #(
    parameter int NDRV = 4
);

    logic [NDRV-1:0] sel_n;
    logic            mtr_n;
    logic            dir_n;
    logic            step_n;
    logic            side_n;
    logic            dkwd_n;
    logic            dkwe_n;
    logic            chng_n;
    logic            index_n;
    logic            trk0_n;
    logic            wprot_n;
    logic            dkrd_n;
    logic            rdy_n;

    modport master (
        output sel_n, mtr_n, dir_n, step_n, side_n, dkwd_n, dkwe_n,
        input  chng_n, index_n, trk0_n, wprot_n, dkrd_n, rdy_n
    );

    modport slave (
        input  sel_n, mtr_n, dir_n, step_n, side_n, dkwd_n, dkwe_n,
        output chng_n, index_n, trk0_n, wprot_n, dkrd_n, rdy_n
    );

endinterface

// File: rtl/fdd_drive_state.sv
// Per-slot drive state: motor latch, cylinder counter, disk-change latches
// and the drive-ID bit index, all driven by synchronised edge strobes.
module fdd_drive_state
    import fdd_pkg::*;
#(
    parameter int  MAXCYL = 79,
    localparam int CYLW   = cylw(MAXCYL)
) (
    input  logic            xclk,
    input  logic            rst_n,
    input  logic            sel_fall_i,
    input  logic            mtr_on_i,
    input  logic            step_rise_i,
    input  logic            sel_i,
    input  logic            emu_i,
    input  logic            step_in_i,
    input  logic            ena_rise_i,
    input  logic            ena_fall_i,
    output logic            motor_o,
    output logic [CYLW-1:0] cyl_o,
    output logic            chng_emu_o,
    output logic            chng_phys_o,
    output logic [4:0]      idx_o
);

    localparam logic [CYLW-1:0] CYL_TOP = CYLW'(MAXCYL);

    logic            motor_q, motor_d;
    logic [CYLW-1:0] cyl_q, cyl_d;
    logic            chng_emu_q, chng_emu_d;
    logic            chng_phys_q, chng_phys_d;
    logic [4:0]      idx_q, idx_d;

    always_comb begin
        motor_d     = motor_q;
        cyl_d       = cyl_q;
        chng_emu_d  = chng_emu_q;
        chng_phys_d = chng_phys_q;
        idx_d       = idx_q;

        // The ID shifter restarts at bit 31 when the motor is switched off
        // and advances on every further select while it stays off.
        if (sel_fall_i) begin
            motor_d = mtr_on_i;
            if (motor_q && !mtr_on_i) begin
                idx_d = IDX_TOP;
            end else if (!motor_q && !mtr_on_i) begin
                idx_d = idx_q - 5'd1;
            end
        end

        // An enable edge swallows a coincident step for this slot.
        if (ena_rise_i) begin
            chng_emu_d = 1'b0;
        end else if (ena_fall_i) begin
            chng_phys_d = 1'b0;
        end else if (step_rise_i && sel_i) begin
            if (emu_i) begin
                chng_emu_d = 1'b1;
                if (step_in_i) begin
                    cyl_d = (cyl_q == CYL_TOP) ? cyl_q : cyl_q + 1'b1;
                end else begin
                    cyl_d = (cyl_q == '0) ? cyl_q : cyl_q - 1'b1;
                end
            end else begin
                chng_phys_d = 1'b1;
            end
        end
    end

    always_ff @(posedge xclk) begin
        if (!rst_n) begin
            motor_q     <= 1'b0;
            cyl_q       <= '0;
            chng_emu_q  <= 1'b1;
            chng_phys_q <= 1'b1;
            idx_q       <= IDX_TOP;
        end else begin
            motor_q     <= motor_d;
            cyl_q       <= cyl_d;
            chng_emu_q  <= chng_emu_d;
            chng_phys_q <= chng_phys_d;
            idx_q       <= idx_d;
        end
    end

    assign motor_o     = motor_q;
    assign cyl_o       = cyl_q;
    assign chng_emu_o  = chng_emu_q;
    assign chng_phys_o = chng_phys_q;
    assign idx_o       = idx_q;

endmodule

// File: rtl/fdd_bus_mux.sv
// Routes each floppy slot to a physical drive or the emulator and answers
// the Amiga bus from per-slot state held in logic.
module fdd_bus_mux
    import fdd_pkg::*;
#(
    parameter int          NDRV     = 4,
    parameter int          MAXCYL   = 79,
    parameter logic [31:0] DRIVE_ID = DRIVE_ID_DEF,
    localparam int         CYLW     = cylw(MAXCYL)
) (
    input  logic            xclk,
    input  logic            rst_n,
    fdd_bus_mux_if.slave    bus,
    input  logic [NDRV-1:0] ena,
    input  logic            vcc_sense,
    input  logic [NDRV-1:0] phys_trk0_n,
    input  logic            dkrd_uc_n,
    input  logic            index_uc_n,
    input  logic            wprot_uc_n,
    output logic [NDRV-1:0] phys_sel_n,
    output logic [NDRV-1:0] phys_mtr_n,
    output logic [NDRV-1:0] sel_uc_n,
    output logic            dir_uc_n,
    output logic            step_uc_n,
    output logic            side_uc_n,
    output logic            dkwd_uc_n,
    output logic            dkwe_uc_n,
    output logic [CYLW-1:0] cyl_uc,
    output logic [NDRV-1:0] motor_uc
);

    logic [NDRV-1:0] sel_s1_q, sel_s2_q, sel_s3_q;
    logic [NDRV-1:0] ena_s1_q, ena_s2_q, ena_s3_q;
    logic [2:0]      mtr_q, dir_q, step_q;

    // Bit 0 is the first sync stage, bit 2 the history flop.
    always_ff @(posedge xclk) begin
        if (!rst_n) begin
            sel_s1_q <= '1;
            sel_s2_q <= '1;
            sel_s3_q <= '1;
            ena_s1_q <= '0;
            ena_s2_q <= '0;
            ena_s3_q <= '0;
            mtr_q    <= '1;
            dir_q    <= '1;
            step_q   <= '1;
        end else begin
            sel_s1_q <= bus.sel_n;
            sel_s2_q <= sel_s1_q;
            sel_s3_q <= sel_s2_q;
            ena_s1_q <= ena;
            ena_s2_q <= ena_s1_q;
            ena_s3_q <= ena_s2_q;
            mtr_q    <= {mtr_q[1:0], bus.mtr_n};
            dir_q    <= {dir_q[1:0], bus.dir_n};
            step_q   <= {step_q[1:0], bus.step_n};
        end
    end

    logic            step_rise;
    logic [CYLW-1:0] cyl_a [NDRV];
    logic [4:0]      idx_a [NDRV];
    logic [NDRV-1:0] chng_emu, chng_phys;

    assign step_rise = rise(step_q[1], step_q[2]);

    for (genvar i = 0; i < NDRV; i++) begin : g_slot
        fdd_drive_state #(.MAXCYL(MAXCYL)) u_state (
            .xclk        (xclk),
            .rst_n       (rst_n),
            .sel_fall_i  (fall(sel_s2_q[i], sel_s3_q[i])),
            .mtr_on_i    (~mtr_q[1]),
            .step_rise_i (step_rise),
            .sel_i       (~sel_s3_q[i]),
            .emu_i       (ena_s3_q[i]),
            .step_in_i   (~dir_q[2]),
            .ena_rise_i  (rise(ena_s2_q[i], ena_s3_q[i])),
            .ena_fall_i  (fall(ena_s2_q[i], ena_s3_q[i])),
            .motor_o     (motor_uc[i]),
            .cyl_o       (cyl_a[i]),
            .chng_emu_o  (chng_emu[i]),
            .chng_phys_o (chng_phys[i]),
            .idx_o       (idx_a[i])
        );
    end

    logic       act_vld;
    logic [1:0] act;

    always_comb begin
        act_vld = 1'b0;
        act     = '0;
        for (int i = NDRV - 1; i >= 0; i--) begin
            if (!bus.sel_n[i]) begin
                act_vld = 1'b1;
                act     = 2'(i);
            end
        end
    end

    logic chng_r, trk0_r, rdy_r, index_r, wprot_r, dkrd_r;

    always_comb begin
        chng_r  = 1'b1;
        trk0_r  = 1'b1;
        rdy_r   = 1'b1;
        index_r = 1'b1;
        wprot_r = 1'b1;
        dkrd_r  = 1'b1;
        cyl_uc  = '0;
        if (act_vld) begin
            if (ena[act]) begin
                chng_r  = chng_emu[act];
                trk0_r  = (cyl_a[act] != '0);
                rdy_r   = motor_uc[act] ? 1'b0 : ~DRIVE_ID[idx_a[act]];
                index_r = index_uc_n;
                wprot_r = wprot_uc_n;
                dkrd_r  = dkrd_uc_n;
                cyl_uc  = cyl_a[act];
            end else begin
                chng_r = chng_phys[act];
                trk0_r = phys_trk0_n[act];
            end
        end
    end

    // Without host power the bus returns idle high; internal state keeps going.
    assign bus.chng_n  = ~vcc_sense | chng_r;
    assign bus.trk0_n  = ~vcc_sense | trk0_r;
    assign bus.rdy_n   = ~vcc_sense | rdy_r;
    assign bus.index_n = ~vcc_sense | index_r;
    assign bus.wprot_n = ~vcc_sense | wprot_r;
    assign bus.dkrd_n  = ~vcc_sense | dkrd_r;

    logic emu_sel;

    assign emu_sel    = |(~bus.sel_n & ena);
    assign phys_sel_n = ena | bus.sel_n;
    assign phys_mtr_n = ena | {NDRV{bus.mtr_n}};
    assign sel_uc_n   = ~ena | bus.sel_n;
    assign dir_uc_n   = ~emu_sel | bus.dir_n;
    assign step_uc_n  = ~emu_sel | bus.step_n;
    assign side_uc_n  = ~emu_sel | bus.side_n;
    assign dkwd_uc_n  = ~emu_sel | bus.dkwd_n;
    assign dkwe_uc_n  = ~emu_sel | bus.dkwe_n;

endmodule

// File: tb/tb_fdd_bus_mux.sv
// Bench for fdd_bus_mux: directed scenarios plus randomized bus activity,
// checked against a transaction-level model of per-slot drive state.
module tb_fdd_bus_mux;

    localparam int          MAXCYL = 79;
    localparam logic [31:0] ID     = 32'hAAAA_AAAA;

    logic       xclk = 1'b0;
    logic       rst_n;
    logic [3:0] ena;
    logic       vcc_sense;
    logic [3:0] phys_trk0_n;
    logic       dkrd_uc_n, index_uc_n, wprot_uc_n;
    logic [3:0] phys_sel_n, phys_mtr_n, sel_uc_n, motor_uc;
    logic       dir_uc_n, step_uc_n, side_uc_n, dkwd_uc_n, dkwe_uc_n;
    logic [6:0] cyl_uc;

    int errs   = 0;
    int checks = 0;

    fdd_bus_mux_if #(.NDRV(4)) bus ();

    fdd_bus_mux #(.NDRV(4), .MAXCYL(MAXCYL), .DRIVE_ID(ID)) dut (
        .xclk        (xclk),
        .rst_n       (rst_n),
        .bus         (bus),
        .ena         (ena),
        .vcc_sense   (vcc_sense),
        .phys_trk0_n (phys_trk0_n),
        .dkrd_uc_n   (dkrd_uc_n),
        .index_uc_n  (index_uc_n),
        .wprot_uc_n  (wprot_uc_n),
        .phys_sel_n  (phys_sel_n),
        .phys_mtr_n  (phys_mtr_n),
        .sel_uc_n    (sel_uc_n),
        .dir_uc_n    (dir_uc_n),
        .step_uc_n   (step_uc_n),
        .side_uc_n   (side_uc_n),
        .dkwd_uc_n   (dkwd_uc_n),
        .dkwe_uc_n   (dkwe_uc_n),
        .cyl_uc      (cyl_uc),
        .motor_uc    (motor_uc)
    );

    always #5 xclk = ~xclk;

    // Model: per-slot cylinder, motor, change latches and reads since motor-off.
    int m_cyl   [4];
    bit m_mot   [4];
    bit m_ce    [4];
    bit m_cp    [4];
    int m_reads [4];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cyl[i] = 0; m_mot[i] = 0; m_ce[i] = 1; m_cp[i] = 1; m_reads[i] = 0;
        end
    endtask

    function automatic int act_slot();
        for (int i = 0; i < 4; i++) if (bus.sel_n[i] === 1'b0) return i;
        return -1;
    endfunction

    function automatic logic e_chng();
        int a = act_slot();
        if (!vcc_sense || a < 0) return 1'b1;
        return ena[a] ? m_ce[a] : m_cp[a];
    endfunction

    function automatic logic e_trk0();
        int a = act_slot();
        if (!vcc_sense || a < 0) return 1'b1;
        if (ena[a]) return (m_cyl[a] == 0) ? 1'b0 : 1'b1;
        return phys_trk0_n[a];
    endfunction

    function automatic logic e_rdy();
        int a = act_slot();
        logic [4:0] bitpos;
        if (!vcc_sense || a < 0 || !ena[a]) return 1'b1;
        if (m_mot[a]) return 1'b0;
        bitpos = 5'(31 - m_reads[a]);
        return ~ID[bitpos];
    endfunction

    function automatic logic e_index();
        int a = act_slot();
        if (!vcc_sense || a < 0 || !ena[a]) return 1'b1;
        return index_uc_n;
    endfunction

    function automatic int e_cyl();
        int a = act_slot();
        if (a < 0 || !ena[a]) return 0;
        return m_cyl[a];
    endfunction

    function automatic logic [3:0] e_motor();
        return {m_mot[3], m_mot[2], m_mot[1], m_mot[0]};
    endfunction

    task automatic settle();
        repeat (4) @(posedge xclk);
        #1;
    endtask

    task automatic model_step(input logic [3:0] skip);
        for (int i = 0; i < 4; i++) begin
            if (!skip[i] && !bus.sel_n[i]) begin
                if (ena[i]) begin
                    m_ce[i] = 1;
                    if (bus.dir_n) m_cyl[i] = (m_cyl[i] > 0) ? m_cyl[i] - 1 : 0;
                    else           m_cyl[i] = (m_cyl[i] < MAXCYL) ? m_cyl[i] + 1 : MAXCYL;
                end else begin
                    m_cp[i] = 1;
                end
            end
        end
    endtask

    task automatic do_step();
        bus.step_n = 1'b0;
        settle();
        bus.step_n = 1'b1;
        model_step(4'b0000);
        settle();
    endtask

    task automatic do_sel(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (bus.sel_n[i] && !v[i]) begin
                bit nm;
                nm = !bus.mtr_n;
                if (m_mot[i] && !nm)       m_reads[i] = 0;
                else if (!m_mot[i] && !nm) m_reads[i]++;
                m_mot[i] = nm;
            end
        end
        bus.sel_n = v;
        settle();
    endtask

    task automatic do_ena(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (!ena[i] && v[i]) m_ce[i] = 0;
            if (ena[i] && !v[i]) m_cp[i] = 0;
        end
        ena = v;
        settle();
    endtask

    task automatic do_mtr(input logic v);
        bus.mtr_n = v;
        settle();
    endtask

    task automatic do_dir(input logic v);
        bus.dir_n = v;
        settle();
    endtask

    task automatic pins_idle();
        bus.sel_n = 4'hF; bus.mtr_n = 1; bus.dir_n = 1; bus.step_n = 1;
        bus.side_n = 1; bus.dkwd_n = 1; bus.dkwe_n = 1;
        ena = 4'h0; vcc_sense = 1; phys_trk0_n = 4'hF;
        dkrd_uc_n = 1; index_uc_n = 1; wprot_uc_n = 1;
    endtask

    task automatic test_reset();
        pins_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge xclk);
        #1;
        model_reset();
        checks++;
        if ({bus.chng_n, bus.rdy_n, bus.trk0_n} !== 3'b111) begin
            errs++; $display("FAIL reset_returns: chng/rdy/trk0=%b expected=111", {bus.chng_n, bus.rdy_n, bus.trk0_n});
        end
        checks++;
        if (motor_uc !== 4'h0) begin
            errs++; $display("FAIL reset_motor: motor_uc=%b expected=0000", motor_uc);
        end
        checks++;
        if (cyl_uc !== 7'd0) begin
            errs++; $display("FAIL reset_cyl: cyl_uc=%0d expected=0", cyl_uc);
        end
        rst_n = 1'b1;
        settle();
    endtask

    task automatic test_step();
        do_ena(4'b0001);
        do_sel(4'b1110);
        checks++;
        if (bus.trk0_n !== 1'b0) begin
            errs++; $display("FAIL step_trk0_home: trk0_n=%b expected=0", bus.trk0_n);
        end
        bus.dir_n = 1'b0;
        settle();
        bus.step_n = 1'b0;
        settle();
        bus.step_n = 1'b1;
        repeat (2) @(posedge xclk);
        #1;
        checks++;
        if (cyl_uc !== 7'd0) begin
            errs++; $display("FAIL step_latency_early: cyl_uc=%0d expected=0", cyl_uc);
        end
        @(posedge xclk);
        #1;
        model_step(4'b0000);
        checks++;
        if (cyl_uc !== 7'd1) begin
            errs++; $display("FAIL step_latency_third: cyl_uc=%0d expected=1", cyl_uc);
        end
        settle();
        repeat (4) do_step();
        checks++;
        if (cyl_uc !== 7'd5 || bus.trk0_n !== 1'b1) begin
            errs++; $display("FAIL step_in5: cyl_uc=%0d trk0_n=%b expected=5,1", cyl_uc, bus.trk0_n);
        end
        do_dir(1'b1);
        repeat (6) do_step();
        checks++;
        if (cyl_uc !== 7'd0 || bus.trk0_n !== 1'b0) begin
            errs++; $display("FAIL step_out_sat0: cyl_uc=%0d trk0_n=%b expected=0,0", cyl_uc, bus.trk0_n);
        end
    endtask

    task automatic test_saturate();
        do_dir(1'b0);
        repeat (85) do_step();
        checks++;
        if (cyl_uc !== 7'd79 || bus.trk0_n !== 1'b1) begin
            errs++; $display("FAIL sat_max: cyl_uc=%0d trk0_n=%b expected=79,1", cyl_uc, bus.trk0_n);
        end
    endtask

    task automatic test_chng();
        do_sel(4'b1101);
        do_ena(4'b0011);
        checks++;
        if (bus.chng_n !== 1'b0) begin
            errs++; $display("FAIL chng_ena_rise: chng_n=%b expected=0", bus.chng_n);
        end
        do_step();
        checks++;
        if (bus.chng_n !== 1'b1 || cyl_uc !== 7'(e_cyl())) begin
            errs++; $display("FAIL chng_step_clear: chng_n=%b cyl_uc=%0d expected=1,%0d", bus.chng_n, cyl_uc, e_cyl());
        end
        do_ena(4'b0001);
        checks++;
        if (bus.chng_n !== 1'b0) begin
            errs++; $display("FAIL chng_ena_fall: chng_n=%b expected=0", bus.chng_n);
        end
        do_step();
        checks++;
        if (bus.chng_n !== 1'b1) begin
            errs++; $display("FAIL chng_phys_step: chng_n=%b expected=1", bus.chng_n);
        end
    endtask

    task automatic test_id();
        do_ena(4'b0001);
        do_sel(4'b1111);
        do_mtr(1'b0);
        do_sel(4'b1110);
        checks++;
        if (motor_uc[0] !== 1'b1 || bus.rdy_n !== 1'b0) begin
            errs++; $display("FAIL id_motor_on: motor=%b rdy_n=%b expected=1,0", motor_uc[0], bus.rdy_n);
        end
        do_sel(4'b1111);
        do_mtr(1'b1);
        do_sel(4'b1110);
        checks++;
        if (motor_uc[0] !== 1'b0 || bus.rdy_n !== 1'b0) begin
            errs++; $display("FAIL id_first: motor=%b rdy_n=%b expected=0,0", motor_uc[0], bus.rdy_n);
        end
        for (int k = 1; k < 32; k++) begin
            do_sel(4'b1111);
            do_sel(4'b1110);
            checks++;
            if (bus.rdy_n !== 1'(k & 1)) begin
                errs++; $display("FAIL id_read%0d: rdy_n=%b expected=%0d", k, bus.rdy_n, k & 1);
            end
        end
    endtask

    task automatic test_priority();
        do_ena(4'b0101);
        do_sel(4'b1011);
        repeat (3) do_step();
        checks++;
        if (cyl_uc !== 7'd3) begin
            errs++; $display("FAIL prio_slot2: cyl_uc=%0d expected=3", cyl_uc);
        end
        do_sel(4'b1010);
        checks++;
        if (cyl_uc !== 7'd79 || bus.chng_n !== e_chng()) begin
            errs++; $display("FAIL prio_slot0: cyl_uc=%0d chng_n=%b expected=79,%b", cyl_uc, bus.chng_n, e_chng());
        end
    endtask

    task automatic test_same_cycle();
        do_sel(4'b0111);
        do_ena(4'b1101);
        repeat (2) do_step();
        do_ena(4'b0101);
        bus.step_n = 1'b0;
        settle();
        ena = 4'b1101;
        bus.step_n = 1'b1;
        m_ce[3] = 0;
        model_step(4'b1000);
        settle();
        checks++;
        if (bus.chng_n !== 1'b0 || cyl_uc !== 7'd2) begin
            errs++; $display("FAIL same_cycle: chng_n=%b cyl_uc=%0d expected=0,2", bus.chng_n, cyl_uc);
        end
    endtask

    task automatic test_vcc();
        do_sel(4'b1110);
        index_uc_n = 1'b0; dkrd_uc_n = 1'b0; wprot_uc_n = 1'b0;
        vcc_sense = 1'b0;
        settle();
        checks++;
        if ({bus.chng_n, bus.index_n, bus.trk0_n, bus.wprot_n, bus.dkrd_n, bus.rdy_n} !== 6'h3F) begin
            errs++; $display("FAIL vcc_off: returns=%b expected=111111",
                {bus.chng_n, bus.index_n, bus.trk0_n, bus.wprot_n, bus.dkrd_n, bus.rdy_n});
        end
        vcc_sense = 1'b1;
        settle();
        checks++;
        if (cyl_uc !== 7'd79 || bus.trk0_n !== 1'b1 || bus.index_n !== 1'b0 || bus.chng_n !== e_chng()) begin
            errs++; $display("FAIL vcc_restore: cyl_uc=%0d trk0_n=%b index_n=%b chng_n=%b expected=79,1,0,%b",
                cyl_uc, bus.trk0_n, bus.index_n, bus.chng_n, e_chng());
        end
        index_uc_n = 1'b1; dkrd_uc_n = 1'b1; wprot_uc_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_dir(1'b1);
        bus.step_n = 1'b0;
        settle();
        bus.step_n = 1'b1;
        @(posedge xclk);
        #1;
        rst_n = 1'b0;
        pins_idle();
        repeat (3) @(posedge xclk);
        #1;
        rst_n = 1'b1;
        model_reset();
        settle();
        do_ena(4'b0001);
        do_sel(4'b1110);
        checks++;
        if (cyl_uc !== 7'd0 || bus.chng_n !== 1'b0 || bus.trk0_n !== 1'b0) begin
            errs++; $display("FAIL reset_mid: cyl_uc=%0d chng_n=%b trk0_n=%b expected=0,0,0", cyl_uc, bus.chng_n, bus.trk0_n);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 5))
                0: do_step();
                1: do_sel(4'($urandom));
                2: do_ena(4'($urandom));
                3: do_mtr(~bus.mtr_n);
                4: do_dir(1'($urandom));
                default: begin
                    index_uc_n = 1'($urandom); phys_trk0_n = 4'($urandom);
                    vcc_sense = ($urandom_range(0, 3) != 0);
                    settle();
                end
            endcase
            checks++;
            if (bus.chng_n !== e_chng()) begin
                errs++; $display("FAIL rnd%0d_chng: chng_n=%b expected=%b", n, bus.chng_n, e_chng());
            end
            checks++;
            if (bus.trk0_n !== e_trk0()) begin
                errs++; $display("FAIL rnd%0d_trk0: trk0_n=%b expected=%b", n, bus.trk0_n, e_trk0());
            end
            checks++;
            if (bus.rdy_n !== e_rdy()) begin
                errs++; $display("FAIL rnd%0d_rdy: rdy_n=%b expected=%b", n, bus.rdy_n, e_rdy());
            end
            checks++;
            if (bus.index_n !== e_index()) begin
                errs++; $display("FAIL rnd%0d_index: index_n=%b expected=%b", n, bus.index_n, e_index());
            end
            checks++;
            if (cyl_uc !== 7'(e_cyl())) begin
                errs++; $display("FAIL rnd%0d_cyl: cyl_uc=%0d expected=%0d", n, cyl_uc, e_cyl());
            end
            checks++;
            if (motor_uc !== e_motor()) begin
                errs++; $display("FAIL rnd%0d_motor: motor_uc=%b expected=%b", n, motor_uc, e_motor());
            end
            checks++;
            if (sel_uc_n !== (~ena | bus.sel_n) || phys_sel_n !== (ena | bus.sel_n)) begin
                errs++; $display("FAIL rnd%0d_sel: sel_uc_n=%b phys_sel_n=%b expected=%b,%b",
                    n, sel_uc_n, phys_sel_n, ~ena | bus.sel_n, ena | bus.sel_n);
            end
            checks++;
            if (dir_uc_n !== ((|(~bus.sel_n & ena)) ? bus.dir_n : 1'b1)) begin
                errs++; $display("FAIL rnd%0d_dir_uc: dir_uc_n=%b expected=%b",
                    n, dir_uc_n, (|(~bus.sel_n & ena)) ? bus.dir_n : 1'b1);
            end
        end
        vcc_sense = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        pins_idle();
        @(posedge xclk);
        #1;
        test_reset();
        test_step();
        test_saturate();
        test_chng();
        test_id();
        test_priority();
        test_same_cycle();
        test_vcc();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
